mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 4096; RAM size in 32-bit words, power of two.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000; value driven on memread_data while in reset.
REQ-003 Parameter TOHOST_ADDR, default 32'h8000_0000; word address of the host-exit register.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 mem_read  in  1  read request this cycle.
REQ-007 mem_wren  in  1  write request this cycle.
REQ-008 mem_addr  in  32  byte address of the request.
REQ-009 mem_size  in  mem_addr_t  access size/signedness: funct3 encoding B=0, H=1, W=2, BU=4, HU=5.
REQ-010 memwrite_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 memread_data  out  32  load data, extended to 32 bits.
REQ-012 ld_en / ld_addr / ld_data  in  1/32/32  backdoor word write used to preload programs.
REQ-013 tohost_valid  out  1  one-cycle pulse on a write to TOHOST_ADDR.
REQ-014 tohost_data  out  32  value of the last tohost write.
REQ-015 access_err  out  1  sticky misaligned or illegal-size flag.

Function
REQ-016 Read latency SHALL be one cycle: a request at edge N yields data on memread_data after edge N.
REQ-017 Requested address, size, and byte offset SHALL be registered with the RAM word, and the lane extract SHALL use the registered copies.
REQ-018 memread_data SHALL hold its last value in every cycle after a cycle with mem_read=0.
REQ-019 Loads: B/H sign-extend, BU/HU zero-extend, W passes through; the byte/half lane is selected by the registered addr[1:0].
REQ-020 Writes SHALL be byte-lane masked: B writes lane addr[1:0]; H writes lanes {addr[1],0} and {addr[1],1}; W writes all four lanes.
REQ-021 RAM index SHALL be addr[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so addresses wrap.
REQ-022 Misaligned accesses (H with addr[0]=1, W with addr[1:0]!=0) and sizes 3/6/7 SHALL NOT write, SHALL return 0 on read, and SHALL set access_err.
REQ-023 mem_read and mem_wren together at the same address: the write commits and the read returns the pre-write data.
REQ-024 A write to TOHOST_ADDR (word-aligned, W only) SHALL NOT update RAM and SHALL pulse tohost_valid for exactly one cycle with tohost_data = memwrite_data.
REQ-025 A read from TOHOST_ADDR SHALL return 0.
REQ-026 When ld_en=1, the backdoor write SHALL take priority over a core write to the same word in that cycle.
REQ-027 A core write that collides with ld_en in the same cycle at a different word SHALL still commit.

Reset
REQ-028 During rst=1: memread_data = RESET_VECTOR, tohost_valid = 0, tohost_data = 0, access_err = 0.
REQ-029 During rst=1, RAM contents are unchanged and ld_en writes still commit, so a preload can be done under reset.
REQ-030 Requests presented during rst SHALL be ignored.
REQ-031 The cycle after rst deasserts, memread_data SHALL still hold RESET_VECTOR until the first read completes.

Structure
REQ-032 mem_addr_t, its B/H/W/BU/HU constants, and the TOHOST default SHALL live in the shared core package.
REQ-033 The byte-enable and load-extract logic SHALL be one sub-module, mem_lane, shared with any future cache.
REQ-034 RAM SHALL be inferable as a single-port-plus-backdoor array with per-byte write enables.

Verification
REQ-035 Reset with RESET_VECTOR=32'h100 -> memread_data=32'h100 during rst and the cycle after.
REQ-036 ld word 0x10 := 32'h8081_82F3; read B @0x13 -> 32'hFFFF_FF80; BU @0x13 -> 32'h0000_0080; H @0x12 -> 32'hFFFF_8081; W @0x10 -> 32'h8081_82F3.
REQ-037 Store B 32'hAA @0x21 then W read @0x20 (word preloaded 0) -> 32'h0000_AA00; store H 32'h1234 @0x22 -> W read 32'h1234_AA00.
REQ-038 Store W @0x02 -> access_err=1 (held), RAM unchanged; read H @0x01 -> 0.
REQ-039 Store W 32'h1 @TOHOST_ADDR -> tohost_valid high exactly one cycle, tohost_data=1, RAM word at index wrap unchanged.
REQ-040 Read and write word 0x40 (old 5, new 9) in the same cycle -> memread_data=5 next cycle, then 9 on the following read.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder and for any later cache: the access-size
// encoding, the default host-exit address and the alignment rule.
package mem_responder_pkg;

  typedef logic [2:0] mem_addr_t;

  localparam mem_addr_t MEM_B  = 3'd0;
  localparam mem_addr_t MEM_H  = 3'd1;
  localparam mem_addr_t MEM_W  = 3'd2;
  localparam mem_addr_t MEM_BU = 3'd4;
  localparam mem_addr_t MEM_HU = 3'd5;

  localparam logic [31:0] TOHOST_DEFAULT = 32'h8000_0000;

  // Encodings 3/6/7 are illegal; halves need addr[0]=0 and words need addr[1:0]=0.
  function automatic logic size_legal(mem_addr_t size, logic [1:0] off);
    case (size)
      MEM_B, MEM_BU: size_legal = 1'b1;
      MEM_H, MEM_HU: size_legal = ~off[0];
      MEM_W:         size_legal = (off == 2'b00);
      default:       size_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between a core (master) and the memory responder (slave),
// including the backdoor preload port and the host-exit outputs.
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic        mem_read;
  logic        mem_wren;
  logic [31:0] mem_addr;
  mem_addr_t   mem_size;
  logic [31:0] memwrite_data;
  logic [31:0] memread_data;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        tohost_valid;
  logic [31:0] tohost_data;
  logic        access_err;

  modport master (
    output mem_read, mem_wren, mem_addr, mem_size, memwrite_data, ld_en, ld_addr, ld_data,
    input  memread_data, tohost_valid, tohost_data, access_err
  );

  modport slave (
    input  mem_read, mem_wren, mem_addr, mem_size, memwrite_data, ld_en, ld_addr, ld_data,
    output memread_data, tohost_valid, tohost_data, access_err
  );
endinterface

// File: rtl/mem_responder_lane.sv
// mem_lane: byte-enable/lane replication for stores and lane select plus sign/zero
// extension for loads. Purely combinational so a cache can reuse it unchanged.
module mem_lane
  import mem_responder_pkg::*;
(
  input  mem_addr_t   st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_lanes,
  input  mem_addr_t   ld_size,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_result
);

  logic [31:0] ld_shifted;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    st_be    = 4'b0000;
    st_lanes = 32'h0;
    case (st_size)
      MEM_B, MEM_BU: begin
        st_be    = 4'b0001 << st_off;
        st_lanes = {4{st_data[7:0]}};
      end
      MEM_H, MEM_HU: begin
        st_be    = st_off[1] ? 4'b1100 : 4'b0011;
        st_lanes = {2{st_data[15:0]}};
      end
      MEM_W: begin
        st_be    = 4'b1111;
        st_lanes = st_data;
      end
      default: ;
    endcase
    if (!size_legal(st_size, st_off)) st_be = 4'b0000;
  end

  assign ld_shifted = ld_word >> {ld_off, 3'b000};
  assign ld_byte    = ld_shifted[7:0];
  assign ld_half    = ld_off[1] ? ld_word[31:16] : ld_word[15:0];

  always_comb begin
    ld_result = 32'h0;
    case (ld_size)
      MEM_B:   ld_result = {{24{ld_byte[7]}}, ld_byte};
      MEM_BU:  ld_result = {24'h0, ld_byte};
      MEM_H:   ld_result = {{16{ld_half[15]}}, ld_half};
      MEM_HU:  ld_result = {16'h0, ld_half};
      MEM_W:   ld_result = ld_word;
      default: ld_result = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Single-cycle-latency word RAM with byte-masked stores, a backdoor preload port and a
// memory-mapped host-exit register used by test programs to report completion.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS  = 4096,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TOHOST_ADDR  = TOHOST_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  mem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0] ram [DEPTH_WORDS];

  logic [AW-1:0] core_idx, back_idx;
  logic          req_legal, at_tohost, wr_tohost, core_we;
  logic [3:0]    st_be;
  logic [31:0]   st_lanes;

  logic          rd_pend, r_ok;
  mem_addr_t     r_size;
  logic [1:0]    r_off;
  logic [31:0]   rd_word, lane_data, lane_out, held;
  logic          tohost_valid_q, access_err_q;
  logic [31:0]   tohost_data_q;
  logic          unused_ld_addr;

  assign core_idx  = bus.mem_addr[AW+1:2];
  assign back_idx  = bus.ld_addr[AW+1:2];
  assign req_legal = size_legal(bus.mem_size, bus.mem_addr[1:0]);
  assign at_tohost = (bus.mem_addr == TOHOST_ADDR);
  assign wr_tohost = !rst && bus.mem_wren && at_tohost && (bus.mem_size == MEM_W);

  // The backdoor owns its word outright; a core write elsewhere in the same cycle still lands.
  assign core_we = !rst && bus.mem_wren && req_legal && !wr_tohost &&
                   !(bus.ld_en && (back_idx == core_idx));

  assign unused_ld_addr = ^{bus.ld_addr[31:AW+2], bus.ld_addr[1:0]};

  mem_lane u_lane (
    .st_size  (bus.mem_size),
    .st_off   (bus.mem_addr[1:0]),
    .st_data  (bus.memwrite_data),
    .st_be    (st_be),
    .st_lanes (st_lanes),
    .ld_size  (r_size),
    .ld_off   (r_off),
    .ld_word  (rd_word),
    .ld_result(lane_data)
  );

  // NOTE: the RAM array is never reset (so preloads survive reset); sequential state uses <= only,
  // which also makes a same-cycle read see the pre-write word.
  always_ff @(posedge clk) begin
    if (bus.ld_en) ram[back_idx] <= bus.ld_data;
    if (core_we) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) ram[core_idx][8*b +: 8] <= st_lanes[8*b +: 8];
      end
    end
    if (!rst && bus.mem_read) rd_word <= ram[core_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend        <= 1'b0;
      r_ok           <= 1'b0;
      r_size         <= MEM_W;
      r_off          <= 2'b00;
      held           <= RESET_VECTOR;
      tohost_valid_q <= 1'b0;
      tohost_data_q  <= 32'h0;
      access_err_q   <= 1'b0;
    end else begin
      rd_pend <= bus.mem_read;
      if (bus.mem_read) begin
        r_ok   <= req_legal && !at_tohost;
        r_size <= bus.mem_size;
        r_off  <= bus.mem_addr[1:0];
      end
      if (rd_pend) held <= lane_out;
      tohost_valid_q <= wr_tohost;
      if (wr_tohost) tohost_data_q <= bus.memwrite_data;
      if ((bus.mem_read || bus.mem_wren) && !req_legal) access_err_q <= 1'b1;
    end
  end

  assign lane_out          = r_ok ? lane_data : 32'h0;
  assign bus.memread_data  = rst ? RESET_VECTOR : (rd_pend ? lane_out : held);
  assign bus.tohost_valid  = tohost_valid_q;
  assign bus.tohost_data   = tohost_data_q;
  assign bus.access_err    = access_err_q;

endmodule
